// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the pipeline, directly upstream of the decoder. It generates the
// fetch PC and issues word reads to instruction memory. Returned words go into a
// small buffer that feeds the decoder. It also handles redirects from execute,
// halting for wfi, and faults on misaligned redirect targets.
//
// Handshakes:
//   imem request : imem_req/imem_addr are held until a cycle with imem_gnt=1,
//                  which accepts the request. Responses come back in order on
//                  imem_rvalid/imem_rdata, at least one cycle after the grant.
//   decoder      : a word moves on every cycle where inst_valid and inst_ready
//                  are both high. inst_valid never depends on inst_ready, and
//                  instruction_code/inst_pc hold the head word until it is taken.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/addr       read request and word-aligned address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   in-order read response
//   inst_valid          head of the buffer is valid (drives decoder enable)
//   instruction_code    head instruction word (0 when the buffer is empty)
//   inst_pc             PC of the head word (0 when the buffer is empty)
//   inst_ready          decoder takes the head this cycle
//   redirect/_pc        flush and restart fetch at redirect_pc
//   halt_req, wake      stop issuing (wfi) / resume
//   fetch_fault         a misaligned redirect target was taken
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction_code,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        wake,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc, fetch_pc_next;
    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic [CNT_W-1:0] discard, discard_next;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_rd_ptr, fifo_wr_ptr;
    logic [PTR_W-1:0] pcq_rd_ptr, pcq_wr_ptr;
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      pcq_pc    [FIFO_DEPTH];
    logic [CNT_W:0]   credit_used;
    logic             issue, push, pop, fifo_empty;

    // Credit uses registered occupancy only, so the consumer never reaches the
    // request path. Every granted read is therefore guaranteed a buffer slot,
    // even if the decoder stalls indefinitely.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req    = (state == ST_RUN) && (credit_used < CREDIT_LIMIT);
    assign imem_addr   = fetch_pc;
    assign issue       = imem_req && imem_gnt;

    assign fifo_empty       = (fifo_count == '0);
    assign inst_valid       = !fifo_empty && !redirect;
    assign instruction_code = fifo_empty ? 32'h0 : fifo_data[fifo_rd_ptr];
    assign inst_pc          = fifo_empty ? 32'h0 : fifo_pc[fifo_rd_ptr];
    assign pop              = inst_valid && inst_ready;
    // Stale responses (discard pending) and any response in a redirect cycle
    // belong to the old path and never enter the buffer.
    assign push             = imem_rvalid && !redirect && (discard == '0);

    assign fetch_fault = (state == ST_FAULT);

    // ---------------- FSM and fetch PC ----------------
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        if (issue) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end
        case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   if (halt_req && !wake) state_next = ST_HALT;
            ST_HALT:  if (wake) state_next = ST_RUN;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_BOOT;
        endcase
        // Redirect beats halt, wake and any sequential advance.
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            state_next    = (redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
        end
    end

    // ---------------- outstanding / discard bookkeeping ----------------
    always_comb begin
        outstanding_next = outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);
        discard_next     = discard;
        if (redirect) begin
            // Everything still in flight after this cycle was fetched for the
            // old path, including a read granted in this very cycle.
            discard_next = outstanding_next;
        end else if (imem_rvalid && (discard != '0)) begin
            discard_next = discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    // ---------------- pointers and occupancy ----------------
    // The PC-in-flight queue tracks every granted read, stale or not, so its
    // head always names the address of the response currently on imem_rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcq_wr_ptr  <= '0;
            pcq_rd_ptr  <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (issue) begin
                pcq_wr_ptr <= pcq_wr_ptr + PTR_W'(1);
            end
            if (imem_rvalid) begin
                pcq_rd_ptr <= pcq_rd_ptr + PTR_W'(1);
            end
            if (redirect) begin
                fifo_wr_ptr <= '0;
                fifo_rd_ptr <= '0;
                fifo_count  <= '0;
            end else begin
                if (push) begin
                    fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // ---------------- storage (no reset needed; guarded by counts) ----------------
    always_ff @(posedge clk) begin
        if (issue) begin
            pcq_pc[pcq_wr_ptr] <= fetch_pc;
        end
        if (push) begin
            fifo_data[fifo_wr_ptr] <= imem_rdata;
            fifo_pc[fifo_wr_ptr]   <= pcq_pc[pcq_rd_ptr];
        end
    end

endmodule
